// File: rtl/regfile_sb.sv
// Multi-port register file with ALU/load writeback, same-cycle read forwarding
// and a per-register load scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 4,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     Nrst,
  input  logic [NRD*ADDR_W-1:0]    rd_addr_i,
  output logic [NRD*DATA_W-1:0]    rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  output logic [ADDR_W:0]          pend_cnt_o,
  output logic [DATA_W-1:0]        reg_top_o,
  output logic                     sb_err_o
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
  logic              sb_err_q, sb_err_d;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;

  // A new load to the same register wins over the returning one.
  always_comb begin
    busy_d = busy_q;
    if (wr1_en_i) busy_d[wr1_addr_i] = 1'b0;
    if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    pend_cnt_d = '0;
    for (int r = 0; r < NREGS; r++)
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(busy_d[r]);
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (sb_set_i && busy_q[sb_addr_i] && !(wr1_en_i && wr1_addr_i == sb_addr_i))
      sb_err_d = 1'b1;
    if (wr0_en_i && busy_q[wr0_addr_i] && !(wr1_en_i && wr1_addr_i == wr0_addr_i))
      sb_err_d = 1'b1;
    if (wr1_en_i && !busy_q[wr1_addr_i])
      sb_err_d = 1'b1;
    if (wr0_en_i && wr1_en_i && wr0_addr_i == wr1_addr_i)
      sb_err_d = 1'b1;
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    rv        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr_i[i*ADDR_W +: ADDR_W];
      rv = regs_q[ra];
      if (BYPASS != 0) begin
        if (wr0_en_i && wr0_addr_i == ra)      rv = wr0_data_i;
        else if (wr1_en_i && wr1_addr_i == ra) rv = wr1_data_i;
      end
      rd_data_o[i*DATA_W +: DATA_W] = rv;
      rd_busy_o[i] = busy_q[ra] && !(wr1_en_i && wr1_addr_i == ra);
    end
  end

  // wr0 is applied last so it wins an address collision with wr1.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      if (wr1_en_i) regs_q[wr1_addr_i] <= wr1_data_i;
      if (wr0_en_i) regs_q[wr0_addr_i] <= wr0_data_i;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;
  assign reg_top_o  = regs_q[NREGS-1];
  assign sb_err_o   = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding instance and a non-forwarding
// instance share all inputs; expected values are hand-computed constants.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NRD    = 4;

  logic                  clk = 1'b0;
  logic                  Nrst;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic                  wr0_en, wr1_en, sb_set;
  logic [ADDR_W-1:0]     wr0_addr, wr1_addr, sb_addr;
  logic [DATA_W-1:0]     wr0_data, wr1_data;

  logic [NRD*DATA_W-1:0] rd_data, b0_rd_data;
  logic [NRD-1:0]        rd_busy, b0_rd_busy;
  logic [ADDR_W:0]       pend_cnt, b0_pend_cnt;
  logic [DATA_W-1:0]     reg_top, b0_reg_top;
  logic                  sb_err, b0_sb_err;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .Nrst(Nrst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .pend_cnt_o(pend_cnt),
    .reg_top_o(reg_top), .sb_err_o(sb_err));

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .Nrst(Nrst), .rd_addr_i(rd_addr), .rd_data_o(b0_rd_data), .rd_busy_o(b0_rd_busy),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .pend_cnt_o(b0_pend_cnt),
    .reg_top_o(b0_reg_top), .sb_err_o(b0_sb_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    sb_set = 1'b0; sb_addr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input int addr);
    rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  function automatic logic [63:0] rdp(input int port);
    return 64'(rd_data[port*DATA_W +: DATA_W]);
  endfunction

  task automatic pulse_reset();
    Nrst = 1'b0;
    #1;
    Nrst = 1'b1;
    #1;
  endtask

  initial begin
    Nrst = 1'b0;
    rd_addr = '0;
    idle();
    #12;
    // Reset state seen through every register and port.
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, g*4 + p);
      #1;
      for (int p = 0; p < NRD; p++) check("reset_rd_data", rdp(p), 64'h0);
      check("reset_rd_busy", 64'(rd_busy), 64'h0);
    end
    check("reset_pend_cnt", 64'(pend_cnt), 64'h0);
    check("reset_reg_top", 64'(reg_top), 64'h0);
    check("reset_sb_err", 64'(sb_err), 64'h0);
    @(negedge clk);
    Nrst = 1'b1;
    tick();

    // ALU write forwarded same cycle, stored next cycle.
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'hDEADBEEF;
    set_rd(0, 3);
    #1;
    check("byp_wr0_fwd", rdp(0), 64'hDEADBEEF);
    check("nobyp_wr0_old", 64'(b0_rd_data[31:0]), 64'h0);
    tick();
    idle();
    #1;
    check("byp_wr0_stored", rdp(0), 64'hDEADBEEF);
    check("nobyp_wr0_stored", 64'(b0_rd_data[31:0]), 64'hDEADBEEF);

    // Load scoreboard set then cleared by load return.
    sb_set = 1'b1; sb_addr = 4'd5;
    set_rd(1, 5);
    #1;
    check("sb_set_not_yet_busy", 64'(rd_busy[1]), 64'h0);
    tick();
    idle();
    #1;
    check("sb_busy_next", 64'(rd_busy[1]), 64'h1);
    check("sb_pend_1", 64'(pend_cnt), 64'h1);
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h1234;
    #1;
    check("wr1_clr_busy_same", 64'(rd_busy[1]), 64'h0);
    check("wr1_fwd", rdp(1), 64'h1234);
    check("nobyp_wr1_old", 64'(b0_rd_data[63:32]), 64'h0);
    tick();
    idle();
    #1;
    check("wr1_pend_0", 64'(pend_cnt), 64'h0);
    check("wr1_stored", rdp(1), 64'h1234);
    check("wr1_no_err", 64'(sb_err), 64'h0);

    // Reissue load while returning one to the same register.
    sb_set = 1'b1; sb_addr = 4'd5;
    tick();
    idle();
    check("reissue_pend_1", 64'(pend_cnt), 64'h1);
    sb_set = 1'b1; sb_addr = 4'd5;
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h55;
    tick();
    idle();
    #1;
    check("reissue_busy", 64'(rd_busy[1]), 64'h1);
    check("reissue_pend", 64'(pend_cnt), 64'h1);
    check("reissue_no_err", 64'(sb_err), 64'h0);
    check("reissue_data", rdp(1), 64'h55);
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h66;
    tick();
    idle();
    check("reissue_drain", 64'(pend_cnt), 64'h0);

    // reg_top shows stored value only.
    wr0_en = 1'b1; wr0_addr = 4'd15; wr0_data = 32'hA5A5A5A5;
    #1;
    check("reg_top_not_bypassed", 64'(reg_top), 64'h0);
    tick();
    idle();
    check("reg_top_stored", 64'(reg_top), 64'hA5A5A5A5);
    check("reg_top_no_err", 64'(sb_err), 64'h0);

    // Same-address collision: wr0 wins, error sticks.
    wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'h1;
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h2;
    set_rd(2, 7);
    #1;
    check("collide_fwd", rdp(2), 64'h1);
    tick();
    idle();
    #1;
    check("collide_stored", rdp(2), 64'h1);
    check("collide_err", 64'(sb_err), 64'h1);
    tick(); tick(); tick();
    check("collide_err_sticky", 64'(sb_err), 64'h1);

    // Spurious load return.
    pulse_reset();
    check("err_cleared", 64'(sb_err), 64'h0);
    wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 32'h9;
    tick();
    idle();
    check("spurious_wr1_err", 64'(sb_err), 64'h1);
    check("spurious_wr1_pend", 64'(pend_cnt), 64'h0);

    // ALU write over an outstanding load.
    pulse_reset();
    sb_set = 1'b1; sb_addr = 4'd9;
    tick();
    idle();
    check("waw_pre_err", 64'(sb_err), 64'h0);
    wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h7;
    tick();
    idle();
    check("waw_err", 64'(sb_err), 64'h1);

    // Second load to a busy register.
    pulse_reset();
    sb_set = 1'b1; sb_addr = 4'd4;
    tick();
    check("dbl_set_pre_err", 64'(sb_err), 64'h0);
    tick();
    idle();
    check("dbl_set_err", 64'(sb_err), 64'h1);
    check("dbl_set_pend", 64'(pend_cnt), 64'h1);

    // Fill scoreboard, then async reset mid-cycle.
    pulse_reset();
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h77;
    tick();
    idle();
    for (int r = 0; r < 16; r++) begin
      sb_set = 1'b1; sb_addr = ADDR_W'(r);
      tick();
      check("fill_pend", 64'(pend_cnt), 64'(r + 1));
    end
    idle();
    check("fill_no_err", 64'(sb_err), 64'h0);
    sb_set = 1'b1; sb_addr = 4'd0;
    tick();
    idle();
    check("full_err", 64'(sb_err), 64'h1);
    check("full_pend_16", 64'(pend_cnt), 64'd16);
    for (int p = 0; p < NRD; p++) set_rd(p, p + 3);
    #1;
    check("full_rd_busy", 64'(rd_busy), 64'hF);
    check("full_r3_data", rdp(0), 64'h77);
    #2;
    Nrst = 1'b0;
    #1;
    check("async_pend", 64'(pend_cnt), 64'h0);
    check("async_busy", 64'(rd_busy), 64'h0);
    check("async_r3", rdp(0), 64'h0);
    check("async_reg_top", 64'(reg_top), 64'h0);
    check("async_err", 64'(sb_err), 64'h0);
    @(negedge clk);
    Nrst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
